// File: rtl/cam_pkg.sv
// Shared definitions for the camera AXI4-Stream output path: FSM states,
// pixel width and FIFO entry layout.
package cam_pkg;

  localparam int CAM_PIX_W   = 16;
  localparam int CAM_ENT_W   = 18;
  localparam int CAM_EOL_BIT = 16;
  localparam int CAM_SOF_BIT = 17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } cam_st_t;

  // Packed so sof lands on bit 17, eol on bit 16, data on [15:0].
  typedef struct packed {
    logic                 sof;
    logic                 eol;
    logic [CAM_PIX_W-1:0] data;
  } cam_ent_t;

endpackage

// File: rtl/cam_axis_fifo.sv
// Synchronous first-word-fall-through FIFO; extra pointer MSB separates full
// from empty. A push into a full FIFO succeeds when a pop happens that cycle.
module cam_axis_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Zero when empty so the stream outputs are quiet out of reset.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge pixel_clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cam_axis_out.sv
// Frames the converted camera pixel stream as AXI4-Stream video (tuser = SOF,
// tlast = EOL) behind a FWFT FIFO. Define CAM_AXIS_BYTE_SWAP_EN to swap bytes.
module cam_axis_out
  import cam_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16,
  parameter bit VS_POL     = 1'b1
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic                 vsync_i,
  input  logic [CAM_PIX_W-1:0] data_i,
  input  logic                 data_de_i,
  output logic [CAM_PIX_W-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic                 ovf_o,
  output logic                 err_o
);
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  cam_st_t           state;
  logic              vs_prev, vs_start;
  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic              full, empty, pop, take, push, ovf_hit;
  logic [CAM_PIX_W-1:0] pix;
  cam_ent_t          wr_ent, rd_ent;

`ifdef CAM_AXIS_BYTE_SWAP_EN
  assign pix = {data_i[7:0], data_i[15:8]};
`else
  assign pix = data_i;
`endif

  assign vs_start = (vsync_i == VS_POL) && (vs_prev != VS_POL);
  assign pop      = !empty && m_axis_tready;
  // A vsync edge owns its cycle; a coincident pixel is not taken.
  assign take     = (state == ST_ACTIVE) && data_de_i && !vs_start;
  assign push     = take && (!full || pop);
  assign ovf_hit  = take && full && !pop;

  assign wr_ent.sof  = (x_cnt == '0) && (y_cnt == '0);
  assign wr_ent.eol  = (x_cnt == X_LAST);
  assign wr_ent.data = pix;

  cam_axis_fifo #(.WIDTH(CAM_ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .push      (push),
    .din       (wr_ent),
    .pop       (pop),
    .dout      (rd_ent),
    .full      (full),
    .empty     (empty)
  );

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = rd_ent.data;
  assign m_axis_tuser  = rd_ent.sof;
  assign m_axis_tlast  = rd_ent.eol;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      vs_prev <= !VS_POL;
      x_cnt   <= '0;
      y_cnt   <= '0;
      ovf_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      vs_prev <= vsync_i;
      if (vs_start) begin
        if (state == ST_ACTIVE && (x_cnt != '0 || y_cnt != '0)) err_o <= 1'b1;
        state <= ST_ACTIVE;
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (ovf_hit) begin
        ovf_o <= 1'b1;
        state <= ST_DROP;
      end else if (push) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          if (y_cnt == Y_LAST) begin
            y_cnt <= '0;
            state <= ST_IDLE;
          end else begin
            y_cnt <= y_cnt + 1'b1;
          end
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_axis_out.sv
// Randomized bench for cam_axis_out against a queue-based frame model
// (small 4x2 frames, 16-deep FIFO).
module tb_cam_axis_out;
  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 16;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        data_de_i = 1'b0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tuser, m_axis_tlast, ovf_o, err_o;

  int total = 0;
  int bad   = 0;

  // Model: expected beats, frame mode (0 wait vsync, 1 in frame, 2 dropping),
  // pixel index within the frame, sticky flags, previous vsync level.
  logic [17:0] q[$];
  int   m_mode, m_pix;
  logic m_ovf, m_err, m_prev;

  cam_axis_out #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .VS_POL(1'b1)) dut (
    .pixel_clk     (pixel_clk),
    .rst           (rst),
    .vsync_i       (vsync_i),
    .data_i        (data_i),
    .data_de_i     (data_de_i),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .ovf_o         (ovf_o),
    .err_o         (err_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_pix = 0;
    m_ovf = 1'b0; m_err = 1'b0; m_prev = 1'b0;
  endtask

  task automatic check_outs();
    chk("tvalid", {31'd0, m_axis_tvalid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("tdata", {16'd0, m_axis_tdata}, {16'd0, q[0][15:0]});
      chk("tlast", {31'd0, m_axis_tlast}, {31'd0, q[0][16]});
      chk("tuser", {31'd0, m_axis_tuser}, {31'd0, q[0][17]});
    end
    chk("ovf", {31'd0, ovf_o}, {31'd0, m_ovf});
    chk("err", {31'd0, err_o}, {31'd0, m_err});
  endtask

  task automatic model_step(input logic vs, input logic de, input logic [15:0] d, input logic rdy);
    logic vs_st;
    logic [15:0] wd;
`ifdef CAM_AXIS_BYTE_SWAP_EN
    wd = {d[7:0], d[15:8]};
`else
    wd = d;
`endif
    vs_st = vs && !m_prev;
    m_prev = vs;
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (vs_st) begin
      if (m_mode == 1 && m_pix != 0) m_err = 1'b1;
      m_mode = 1; m_pix = 0;
    end else if (de && m_mode == 1) begin
      if (q.size() == D) begin
        m_ovf = 1'b1; m_mode = 2;
      end else begin
        q.push_back({m_pix == 0, (m_pix % H) == H - 1, wd});
        m_pix++;
        if (m_pix == H * V) begin m_mode = 0; m_pix = 0; end
      end
    end
  endtask

  // Called on a negedge: check, apply inputs, advance the model, wait a cycle.
  task automatic step(input logic vs, input logic de, input logic [15:0] d, input logic rdy);
    check_outs();
    vsync_i = vs; data_de_i = de; data_i = d; m_axis_tready = rdy;
    model_step(vs, de, d, rdy);
    @(negedge pixel_clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, rdy);
  endtask

  task automatic vs_pulse(input logic rdy);
    step(1'b1, 1'b0, 16'h0, rdy);
    step(1'b1, 1'b0, 16'h0, rdy);
    step(1'b0, 1'b0, 16'h0, rdy);
  endtask

  task automatic pix(input logic [15:0] d, input logic rdy);
    step(1'b0, 1'b1, d, rdy);
    step(1'b0, 1'b0, 16'h0, rdy);
  endtask

  task automatic rpix(input int n, input logic rdy);
    for (int i = 0; i < n; i++) pix(16'($urandom), rdy);
  endtask

  initial begin
    model_reset();
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tdata",  {16'd0, m_axis_tdata}, 32'd0);
    chk("rst_tuser",  {31'd0, m_axis_tuser}, 32'd0);
    chk("rst_tlast",  {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_ovf",    {31'd0, ovf_o}, 32'd0);
    chk("rst_err",    {31'd0, err_o}, 32'd0);
    rst = 1'b0;
    @(negedge pixel_clk);

    // Pre-sync pixels are discarded, then basic framing with counting data.
    rpix(5, 1'b1);
    idle(3, 1'b1);
    vs_pulse(1'b1);
    for (int i = 1; i <= 8; i++) pix(16'(i), 1'b1);
    idle(4, 1'b1);

    // Backpressure: 10 stalled cycles mid-line.
    vs_pulse(1'b1);
    rpix(2, 1'b1);
    rpix(5, 1'b0);
    rpix(1, 1'b1);
    idle(20, 1'b1);

    // Overflow: two full frames fill 16 entries, 17th pixel overflows.
    vs_pulse(1'b0);
    rpix(8, 1'b0);
    vs_pulse(1'b0);
    rpix(8, 1'b0);
    vs_pulse(1'b0);
    rpix(4, 1'b0);
    chk("ovf_set", {31'd0, ovf_o}, 32'd1);
    idle(24, 1'b1);
    vs_pulse(1'b1);
    rpix(8, 1'b1);
    idle(4, 1'b1);

    // Short frame: vsync after 5 of 8 pixels.
    vs_pulse(1'b1);
    rpix(5, 1'b1);
    vs_pulse(1'b1);
    rpix(8, 1'b1);
    idle(4, 1'b1);
    chk("err_set", {31'd0, err_o}, 32'd1);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step(($urandom % 40) == 0, ($urandom % 3) != 0, 16'($urandom), ($urandom % 4) != 0);
    idle(24, 1'b1);

    // Reset mid-frame with data held in the FIFO.
    vs_pulse(1'b1);
    rpix(3, 1'b0);
    rst = 1'b1;
    #1;
    chk("mrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("mrst_tdata",  {16'd0, m_axis_tdata}, 32'd0);
    chk("mrst_tuser",  {31'd0, m_axis_tuser}, 32'd0);
    chk("mrst_tlast",  {31'd0, m_axis_tlast}, 32'd0);
    chk("mrst_ovf",    {31'd0, ovf_o}, 32'd0);
    chk("mrst_err",    {31'd0, err_o}, 32'd0);
    model_reset();
    @(negedge pixel_clk);
    rst = 1'b0;
    @(negedge pixel_clk);
    rpix(4, 1'b1);
    vs_pulse(1'b1);
    rpix(8, 1'b1);
    idle(6, 1'b1);
    chk("end_empty", {31'd0, m_axis_tvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
